// File: rtl/alu_pkg.sv
// Shared definitions for the multi-cycle ALU paths: default operand geometry and FSM state encoding.
package alu_pkg;

  localparam int WIDTH_DEF  = 32;
  localparam int SLICE_DEF  = 4;
  localparam int NUM_SLICES = WIDTH_DEF / SLICE_DEF;
  localparam int CNT_W      = (NUM_SLICES > 1) ? $clog2(NUM_SLICES) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/sub_slice_cla.sv
// Combinational 4-bit carry-lookahead add slice; invert_b turns it into the subtract slice (a + ~b + cin).
module sub_slice_cla (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  input  logic       invert_b,
  output logic [3:0] sum,
  output logic       cout
);

  logic [3:0] bx;
  logic [3:0] g;
  logic [3:0] p;
  logic [4:0] c;

  assign bx = invert_b ? ~b : b;
  assign g  = a & bx;
  assign p  = a ^ bx;

  assign c[0] = cin;
  assign c[1] = g[0] | (p[0] & cin);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
  assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & cin);

  assign sum  = p ^ c[3:0];
  assign cout = c[4];

endmodule

// File: rtl/serial_subtractor.sv
// Serial op1 - op2, one 4-bit slice per cycle LSB first, with start/busy/done handshake and result flags.
// Optional SERIAL_SUB_ADD_MODE_EN adds i_sub, selecting add (i_sub=0) or subtract (i_sub=1).
module serial_subtractor
  import alu_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int SLICE = SLICE_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_op1,
  input  logic [WIDTH-1:0] i_op2,
`ifdef SERIAL_SUB_ADD_MODE_EN
  input  logic             i_sub,
`endif
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_diff,
  output logic             o_borrow,
  output logic             o_zero,
  output logic             o_sign,
  output logic             o_overflow
);

  localparam int NSL = WIDTH / SLICE;
  localparam int CW  = (NSL > 1) ? $clog2(NSL) : 1;

  state_e           state;
  state_e           state_nxt;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] op1_q;
  logic [WIDTH-1:0] op2_q;
  logic             carry_q;
  logic             sub_q;
  logic             sub_in;
  logic             accept;
  logic             last;
  logic [SLICE-1:0] slice_a;
  logic [SLICE-1:0] slice_b;
  logic [SLICE-1:0] slice_sum;
  logic             slice_cout;
  logic [WIDTH-1:0] final_diff;

`ifdef SERIAL_SUB_ADD_MODE_EN
  assign sub_in = i_sub;
`else
  assign sub_in = 1'b1;
`endif

  // Subtract reports borrow (inverted carry); add reports the raw carry-out.
  function automatic logic f_borrow(input logic sub, input logic cout);
    return sub ? ~cout : cout;
  endfunction

  function automatic logic f_overflow(input logic sub, input logic a_msb, input logic b_msb,
                                      input logic d_msb);
    return sub ? ((a_msb != b_msb) & (d_msb != a_msb))
               : ((a_msb == b_msb) & (d_msb != a_msb));
  endfunction

  assign accept     = i_start & (state != RUN);
  assign last       = (cnt == CW'(NSL - 1));
  assign slice_a    = op1_q[cnt*SLICE +: SLICE];
  assign slice_b    = op2_q[cnt*SLICE +: SLICE];
  assign final_diff = {slice_sum, o_diff[WIDTH-SLICE-1:0]};

  sub_slice_cla u_slice (
    .a        (slice_a),
    .b        (slice_b),
    .cin      (carry_q),
    .invert_b (sub_q),
    .sum      (slice_sum),
    .cout     (slice_cout)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    o_busy    = 1'b0;
    o_done    = 1'b0;
    case (state)
      IDLE: if (i_start) state_nxt = RUN;
      RUN: begin
        o_busy = 1'b1;
        if (last) state_nxt = DONE;
      end
      DONE: begin
        o_done    = 1'b1;
        state_nxt = i_start ? RUN : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Operand capture: data only, no reset needed.
  always_ff @(posedge clk) begin
    if (accept) begin
      op1_q <= i_op1;
      op2_q <= i_op2;
    end
  end

  // Slice iteration: the final slice also commits the flags.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt        <= '0;
      carry_q    <= 1'b0;
      sub_q      <= 1'b1;
      o_diff     <= '0;
      o_borrow   <= 1'b0;
      o_zero     <= 1'b0;
      o_sign     <= 1'b0;
      o_overflow <= 1'b0;
    end else if (accept) begin
      cnt     <= '0;
      carry_q <= sub_in;
      sub_q   <= sub_in;
    end else if (state == RUN) begin
      o_diff[cnt*SLICE +: SLICE] <= slice_sum;
      carry_q                    <= slice_cout;
      cnt                        <= cnt + 1'b1;
      if (last) begin
        cnt        <= '0;
        o_borrow   <= f_borrow(sub_q, slice_cout);
        o_zero     <= (final_diff == '0);
        o_sign     <= final_diff[WIDTH-1];
        o_overflow <= f_overflow(sub_q, op1_q[WIDTH-1], op2_q[WIDTH-1], final_diff[WIDTH-1]);
      end
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Randomised and directed bench for serial_subtractor against a plain-arithmetic reference model.
module tb_serial_subtractor;

  localparam int W   = 32;
  localparam int NSL = W / 4;

  logic         clk;
  logic         rst_n;
  logic         i_start;
  logic [W-1:0] i_op1;
  logic [W-1:0] i_op2;
  logic         i_sub;
  logic         o_busy;
  logic         o_done;
  logic [W-1:0] o_diff;
  logic         o_borrow;
  logic         o_zero;
  logic         o_sign;
  logic         o_overflow;

  int n_vec;
  int n_err;

  logic [W-1:0] exp_diff;
  logic         exp_brw;
  logic         exp_zero;
  logic         exp_sign;
  logic         exp_ovf;

  serial_subtractor #(.WIDTH(W), .SLICE(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_start    (i_start),
    .i_op1      (i_op1),
    .i_op2      (i_op2),
`ifdef SERIAL_SUB_ADD_MODE_EN
    .i_sub      (i_sub),
`endif
    .o_busy     (o_busy),
    .o_done     (o_done),
    .o_diff     (o_diff),
    .o_borrow   (o_borrow),
    .o_zero     (o_zero),
    .o_sign     (o_sign),
    .o_overflow (o_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer arithmetic, signed overflow from the exact signed result range.
  task automatic model(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub);
    logic [W:0] wide;
    longint     sa;
    longint     sb;
    longint     sr;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (sub) begin
      wide    = {1'b0, a} - {1'b0, b};
      exp_brw = (a < b);
      sr      = sa - sb;
    end else begin
      wide    = {1'b0, a} + {1'b0, b};
      exp_brw = wide[W];
      sr      = sa + sb;
    end
    exp_diff = wide[W-1:0];
    exp_zero = (exp_diff == '0);
    exp_sign = exp_diff[W-1];
    exp_ovf  = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
  endtask

  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub);
    @(negedge clk);
    i_op1   = a;
    i_op2   = b;
    i_sub   = sub;
    i_start = 1'b1;
    @(posedge clk);
    #1;
    i_start = 1'b0;
    chk("busy_after_start", 64'(o_busy), 64'd1);
  endtask

  // Waits for o_done counting edges after acceptance; optionally pulses a stray start mid-run.
  task automatic wait_done(input int pulse_at);
    int cyc;
    logic got;
    cyc = 0;
    got = 1'b0;
    while (cyc < 20 && !got) begin
      @(posedge clk);
      #1;
      cyc++;
      got = o_done;
      if (cyc == pulse_at) begin
        i_start = 1'b1;
        i_op1   = $urandom;
        i_op2   = $urandom;
        i_sub   = ~i_sub;
      end else begin
        i_start = 1'b0;
      end
    end
    chk("done_seen", 64'(got), 64'd1);
    chk("latency", 64'(cyc), 64'(NSL));
  endtask

  task automatic check_result();
    chk("diff", 64'(o_diff), 64'(exp_diff));
    chk("borrow", 64'(o_borrow), 64'(exp_brw));
    chk("zero", 64'(o_zero), 64'(exp_zero));
    chk("sign", 64'(o_sign), 64'(exp_sign));
    chk("overflow", 64'(o_overflow), 64'(exp_ovf));
    chk("busy_in_done", 64'(o_busy), 64'd0);
  endtask

  task automatic run(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub, input int pulse_at);
    model(a, b, sub);
    start_op(a, b, sub);
    wait_done(pulse_at);
    check_result();
  endtask

  task automatic idle_hold();
    @(posedge clk);
    #1;
    chk("done_pulse_end", 64'(o_done), 64'd0);
    chk("idle_not_busy", 64'(o_busy), 64'd0);
    chk("diff_held", 64'(o_diff), 64'(exp_diff));
    chk("borrow_held", 64'(o_borrow), 64'(exp_brw));
  endtask

  task automatic check_cleared(input string tag);
    chk({tag, "_busy"}, 64'(o_busy), 64'd0);
    chk({tag, "_done"}, 64'(o_done), 64'd0);
    chk({tag, "_diff"}, 64'(o_diff), 64'd0);
    chk({tag, "_flags"}, 64'({o_borrow, o_zero, o_sign, o_overflow}), 64'd0);
  endtask

  initial begin
    int seen;
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    logic         rs;
    n_vec   = 0;
    n_err   = 0;
    rst_n   = 1'b0;
    i_start = 1'b0;
    i_op1   = '0;
    i_op2   = '0;
    i_sub   = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_cleared("reset");
    @(negedge clk);
    rst_n = 1'b1;

    run(32'h0000_0005, 32'h0000_0003, 1'b1, 0);
    idle_hold();
    run(32'h0000_0003, 32'h0000_0005, 1'b1, 0);
    idle_hold();
    run(32'h8000_0000, 32'h0000_0001, 1'b1, 0);
    run(32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b1, 0);
    idle_hold();
    // Stray start in the middle of RUN must not disturb the captured operands.
    run(32'h1234_5678, 32'h1234_5678, 1'b1, 3);
    idle_hold();

    // Reset in the fourth RUN cycle aborts the operation.
    start_op(32'hDEAD_BEEF, 32'h0BAD_F00D, 1'b1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check_cleared("abort");
    rst_n = 1'b1;
    seen = 0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk);
      #1;
      if (o_done) seen++;
    end
    chk("no_done_after_abort", 64'(seen), 64'd0);

    run(32'h0000_0010, 32'h0000_0001, 1'b1, 0);
    // Next launch happens from the DONE cycle: no idle gap.
    run(32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 0);
    idle_hold();

`ifdef SERIAL_SUB_ADD_MODE_EN
    run(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 0);
    idle_hold();
    run(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 0);
    idle_hold();
`endif

    for (int n = 0; n < 30; n++) begin
      ra = $urandom;
      rb = (n % 7 == 0) ? ra : $urandom;
`ifdef SERIAL_SUB_ADD_MODE_EN
      rs = 1'($urandom_range(0, 1));
`else
      rs = 1'b1;
`endif
      run(ra, rb, rs, (n % 5 == 1) ? 2 : 0);
      if (n % 3 == 0) idle_hold();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
